// File: rtl/swt_debounce_if.sv
// Switch debouncer signal bundle: raw board switches in, debounced levels and
// change notification out.
interface swt_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] swt_raw;
    logic [WIDTH-1:0] swt;
    logic             swt_chg;
    logic [WIDTH-1:0] chg_mask;
    logic             busy;

    modport master (
        output swt_raw,
        input  swt, swt_chg, chg_mask, busy
    );

    modport slave (
        input  swt_raw,
        output swt, swt_chg, chg_mask, busy
    );
endinterface

// File: rtl/swt_debounce.sv
// Multi-bit switch debouncer: 2-flop synchronizer, shared sample-tick prescaler,
// and a per-bit qualify counter that accepts a level after STABLE_CNT differing ticks.
module swt_debounce #(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 4
) (
    input  logic          clk,
    input  logic          reset,
    swt_debounce_if.slave sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

    typedef enum logic {STABLE, QUALIFY} bit_state_t;

    logic [WIDTH-1:0] sync_p0, sync_p1;
    logic [PW-1:0]    presc;
    logic             tick;

    bit_state_t       state     [WIDTH];
    bit_state_t       state_nxt [WIDTH];
    logic [CW-1:0]    cnt       [WIDTH];
    logic [CW-1:0]    cnt_nxt   [WIDTH];

    logic [WIDTH-1:0] swt_q;
    logic [WIDTH-1:0] accept;
    logic             busy_nxt;
    logic             chg_q;
    logic [WIDTH-1:0] mask_q;
    logic             busy_q;

    // Stage p0/p1: metastability guard on the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw.swt_raw;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == PRESC_MAX);

    always_comb begin
        accept   = '0;
        busy_nxt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            if (tick) begin
                if (sync_p1[i] == swt_q[i]) begin
                    cnt_nxt[i]   = '0;
                    state_nxt[i] = STABLE;
                end else if (cnt[i] >= CNT_LAST) begin
                    // Enough consecutive disagreeing ticks: take the new level
                    cnt_nxt[i]   = '0;
                    state_nxt[i] = STABLE;
                    accept[i]    = 1'b1;
                end else begin
                    cnt_nxt[i]   = cnt[i] + CW'(1);
                    state_nxt[i] = QUALIFY;
                end
            end
            if (cnt_nxt[i] != '0) begin
                busy_nxt = 1'b1;
            end
        end
    end

    // Stage p2: debounced level, change strobe and busy all register together
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
            swt_q  <= '0;
            chg_q  <= 1'b0;
            mask_q <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            swt_q  <= swt_q ^ accept;
            chg_q  <= |accept;
            mask_q <= accept;
            busy_q <= busy_nxt;
        end
    end

    assign sw.swt      = swt_q;
    assign sw.swt_chg  = chg_q;
    assign sw.chg_mask = mask_q;
    assign sw.busy     = busy_q;
endmodule

// File: tb/tb_swt_debounce.sv
// Randomized and directed bench for swt_debounce against a cycle-level
// behavioural model built from the acceptance rules (delay line + tick counting).
module tb_swt_debounce;
    localparam int W  = 8;
    localparam int TD = 4;
    localparam int SC = 3;

    logic clk;
    logic reset;

    swt_debounce_if #(.WIDTH(W)) bus ();

    swt_debounce #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_CNT(SC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nerr;
    int npulse;
    logic [W-1:0] last_mask;

    // Reference model state
    logic [W-1:0] d1, d2;
    logic [W-1:0] m_swt, m_mask;
    logic         m_chg, m_busy;
    int           m_run [W];
    longint       t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock: update the model for this edge, then compare after it.
    task automatic cyc();
        logic [W-1:0] s;
        logic [W-1:0] acc;
        if (reset) begin
            d1 = '0; d2 = '0; m_swt = '0; m_mask = '0; m_chg = 1'b0; m_busy = 1'b0; t = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            s   = d2;
            d2  = d1;
            d1  = bus.swt_raw;
            acc = '0;
            if ((t % TD) == TD - 1) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] == m_swt[i]) m_run[i] = 0;
                    else begin
                        m_run[i]++;
                        if (m_run[i] == SC) begin
                            acc[i]   = 1'b1;
                            m_run[i] = 0;
                        end
                    end
                end
            end
            t++;
            m_swt  = m_swt ^ acc;
            m_chg  = (acc != '0);
            m_mask = acc;
            m_busy = 1'b0;
            for (int i = 0; i < W; i++) if (m_run[i] != 0) m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("swt", bus.swt, m_swt);
        chk("swt_chg", bus.swt_chg, m_chg);
        chk("chg_mask", bus.chg_mask, m_mask);
        chk("busy", bus.busy, m_busy);
        if (bus.swt_chg === 1'b1) begin
            npulse++;
            last_mask = bus.chg_mask;
        end
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wait_lat(input string tag, input logic [W-1:0] target);
        int n;
        n = 0;
        while (bus.swt !== target && n < 40) begin
            cyc();
            n++;
        end
        chk(tag, ((n >= 11) && (n <= 14)) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] old, tgt;
        int n, len;
        nvec = 0; nerr = 0; npulse = 0; last_mask = '0;
        d1 = '0; d2 = '0; m_swt = '0; m_mask = '0; m_chg = 1'b0; m_busy = 1'b0; t = 0;
        for (int i = 0; i < W; i++) m_run[i] = 0;

        // Reset with switches low, then idle
        reset = 1'b1;
        bus.swt_raw = '0;
        @(negedge clk);
        hold(3);
        chk("rst_swt", bus.swt, 32'h0);
        chk("rst_busy", bus.busy, 32'h0);
        reset = 1'b0;
        npulse = 0;
        hold(50);
        chk("idle_swt", bus.swt, 32'h0);
        chk("idle_pulses", npulse, 32'd0);
        chk("idle_busy", bus.busy, 32'h0);

        // Clean step to A5
        npulse = 0;
        bus.swt_raw = 8'hA5;
        wait_lat("lat_a5", 8'hA5);
        hold(10);
        chk("a5_swt", bus.swt, 32'hA5);
        chk("a5_pulses", npulse, 32'd1);
        chk("a5_mask", last_mask, 32'hA5);

        // Short glitch on bit0 is rejected
        npulse = 0;
        for (int k = 0; k < 5; k++) begin
            bus.swt_raw = 8'hA5 ^ ((k % 2 == 0) ? 8'h01 : 8'h00);
            cyc();
        end
        bus.swt_raw = 8'hA5;
        n = 0;
        while (bus.busy !== 1'b0 && n < 8) begin
            cyc();
            n++;
        end
        chk("glitch_busy", bus.busy, 32'h0);
        hold(10);
        chk("glitch_swt", bus.swt, 32'hA5);
        chk("glitch_pulses", npulse, 32'd0);

        // Bouncing bit3 from zero, then stable high
        reset = 1'b1;
        bus.swt_raw = '0;
        hold(2);
        reset = 1'b0;
        npulse = 0;
        for (int k = 0; k < 30; k++) begin
            bus.swt_raw = (((k / 3) % 2) == 0) ? 8'h08 : 8'h00;
            cyc();
        end
        chk("bounce_swt", bus.swt, 32'h0);
        chk("bounce_pulses", npulse, 32'd0);
        bus.swt_raw = 8'h08;
        hold(20);
        chk("bounce_final", bus.swt, 32'h08);
        chk("bounce_pulse1", npulse, 32'd1);
        chk("bounce_mask", last_mask, 32'h08);

        // Reset in the middle of qualifying FF
        bus.swt_raw = 8'hFF;
        hold(8);
        reset = 1'b1;
        cyc();
        chk("midrst_swt", bus.swt, 32'h0);
        chk("midrst_chg", bus.swt_chg, 32'h0);
        chk("midrst_mask", bus.chg_mask, 32'h0);
        chk("midrst_busy", bus.busy, 32'h0);
        reset = 1'b0;
        npulse = 0;
        wait_lat("lat_ff", 8'hFF);
        hold(4);
        chk("ff_pulses", npulse, 32'd1);
        chk("ff_mask", last_mask, 32'hFF);

        // Walk all even values
        old = 8'hFF;
        for (int v = 0; v < 256; v += 2) begin
            npulse = 0;
            bus.swt_raw = 8'(v);
            hold(20);
            chk("step_swt", bus.swt, 32'(v));
            chk("step_pulses", npulse, 32'd1);
            chk("step_mask", last_mask, 32'(old ^ 8'(v)));
            old = 8'(v);
        end

        // Random segments with bounce noise and occasional reset
        for (int seg = 0; seg < 150; seg++) begin
            tgt = 8'($urandom);
            len = $urandom_range(1, 25);
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
            end
            for (int j = 0; j < len; j++) begin
                bus.swt_raw = tgt ^ (($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00);
                cyc();
            end
        end
        bus.swt_raw = 8'h3C;
        hold(20);
        chk("rand_final", bus.swt, 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/swt_debounce.md
SWT_DEBOUNCE -- requirements
Module: swt_debounce

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, number of switch inputs.
REQ-002 The block SHALL provide parameter TICK_DIV, default 100000, clk cycles per sample tick; legal range >= 1.
REQ-003 The block SHALL provide parameter STABLE_CNT, default 4, consecutive differing ticks needed to accept a new level; legal range >= 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 swt_raw  input  WIDTH  raw board switches, asynchronous to clk, may bounce.
REQ-007 swt  output  WIDTH  debounced, registered switch levels; feeds the downstream LED logic's swt input.
REQ-008 swt_chg  output  1  one-cycle pulse when any bit of swt changes.
REQ-009 chg_mask  output  WIDTH  bits of swt that changed; valid only while swt_chg=1, else 0.
REQ-010 busy  output  1  high while any bit has a nonzero qualification count.

Function
REQ-011 Each swt_raw bit SHALL pass through a two-flop synchronizer; sync output is raw delayed by exactly 2 clk cycles.
REQ-012 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; internal tick asserts for one cycle when count = TICK_DIV-1 (every cycle when TICK_DIV=1).
REQ-013 Each bit SHALL own a counter of width clog2(STABLE_CNT+1); counters update only on tick cycles.
REQ-014 On tick, if sync bit equals swt bit, that bit's counter SHALL clear to 0.
REQ-015 On tick, if sync bit differs and counter < STABLE_CNT-1, counter SHALL increment by 1.
REQ-016 On tick, if sync bit differs and counter = STABLE_CNT-1, swt bit SHALL take sync value on that edge and counter SHALL clear to 0.
REQ-017 Per-bit behaviour is a two-state machine: STABLE (counter=0) -> QUALIFY on first differing tick (STABLE_CNT>1); QUALIFY -> STABLE on matching tick (reject) or on acceptance.
REQ-018 swt_chg and chg_mask SHALL be registered and assert on the same edge swt updates, for exactly one cycle.
REQ-019 Multiple bits accepted on the same tick SHALL produce a single swt_chg pulse with all those bits set in chg_mask.
REQ-020 Latency from a stable raw edge to swt update SHALL be between 2+TICK_DIV*(STABLE_CNT-1)+1 and 2+TICK_DIV*STABLE_CNT cycles.
REQ-021 A raw pulse lasting fewer than TICK_DIV*(STABLE_CNT-1)+1 cycles SHALL never change swt.
REQ-022 Bits SHALL qualify independently; a bouncing bit SHALL not delay or reset another bit's counter.
REQ-023 busy SHALL be the registered OR of all counters being nonzero, updated on the same edge as the counters.

Reset
REQ-024 While reset=1 at a clk edge: sync flops, prescaler, all counters, swt, swt_chg, chg_mask and busy SHALL become 0.
REQ-025 Reset asserted mid-qualification SHALL discard partial counts; prescaler restarts at 0 on the first cycle after reset deasserts.
REQ-026 After reset, swt_raw levels that are 1 SHALL be accepted through normal qualification (no preload), producing a swt_chg pulse.

Verification (bench uses TICK_DIV=4, STABLE_CNT=3)
REQ-027 Reset with swt_raw=8'h00, hold 50 cycles -> swt=8'h00, swt_chg never asserted, busy=0.
REQ-028 After reset, set swt_raw=8'hA5 and hold -> swt becomes 8'hA5 in 11..14 cycles, single swt_chg pulse with chg_mask=8'hA5.
REQ-029 From swt=8'hA5, toggle bit0 for 5 cycles then return -> swt stays 8'hA5, no swt_chg, busy returns to 0 within 8 cycles.
REQ-030 From swt=8'h00, bounce bit3 every 3 cycles for 30 cycles, then hold 1 -> swt=8'h08 only after hold, exactly one pulse with chg_mask=8'h08.
REQ-031 Start qualifying swt_raw=8'hFF, assert reset for 1 cycle after 8 cycles -> all outputs 0, then swt=8'hFF 11..14 cycles after reset release.
REQ-032 Step every even value 0..254 on swt_raw, holding each 20 cycles -> swt matches swt_raw at the end of each hold, with chg_mask = old XOR new.
